// File: rtl/bg_rom_arbiter_if.sv
// Bundles the bg_rom_arbiter's signals: the VGA pixel stream, the background ROM port,
// the palette index and the collision query handshake.
// slave  = arbiter side, master = environment side (VGA, ROM, palette LUT, game logic).
interface bg_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 4
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] pix_index;
  logic              q_req;
  logic [9:0]        q_x;
  logic [9:0]        q_y;
  logic              q_ack;
  logic [DATA_W-1:0] q_data;
  logic              q_oob;
  logic [15:0]       q_wait_cycles;

  modport slave (
    input  DrawX, DrawY, blank, rom_q, q_req, q_x, q_y,
    output rom_address, pix_index, q_ack, q_data, q_oob, q_wait_cycles
  );

  modport master (
    output DrawX, DrawY, blank, rom_q, q_req, q_x, q_y,
    input  rom_address, pix_index, q_ack, q_data, q_oob, q_wait_cycles
  );
endinterface

// File: rtl/bg_rom_arbiter.sv
// Shares a single-port background ROM (1-cycle read latency) between the VGA display fetch
// and a game-logic collision query port. The display always owns the ROM during visible
// pixels; queries are issued only in H/V blanking slots.
// Optional build macro BGARB_PERF_EN: enables the 16-bit saturating query stall counter
// on q_wait_cycles. When it is undefined, q_wait_cycles is tied to 0.
module bg_rom_arbiter #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned IMG_W  = 105,
  parameter int unsigned IMG_H  = 117,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 4
) (
  input logic               vga_clk,
  input logic               reset_n,
  bg_rom_arbiter_if.slave   bus
);

  // Address arithmetic width; wide enough for 1023*IMG_H and the final sum
  localparam int unsigned CALC_W = 20;

  localparam logic [9:0]        H_VIS_C = 10'(H_VIS);
  localparam logic [9:0]        V_VIS_C = 10'(V_VIS);
  localparam logic [9:0]        IMG_W_C = 10'(IMG_W);
  localparam logic [9:0]        IMG_H_C = 10'(IMG_H);
  localparam logic [CALC_W-1:0] IMG_W_K = CALC_W'(IMG_W);
  localparam logic [CALC_W-1:0] IMG_H_K = CALC_W'(IMG_H);
  localparam logic [CALC_W-1:0] H_VIS_K = CALC_W'(H_VIS);
  localparam logic [CALC_W-1:0] V_VIS_K = CALC_W'(V_VIS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [9:0]        q_x_l, q_x_nxt;
  logic [9:0]        q_y_l, q_y_nxt;
  logic              q_ack_r, q_ack_nxt;
  logic [DATA_W-1:0] q_data_r, q_data_nxt;
  logic              q_oob_r, q_oob_nxt;
  logic              blank_d1;
  logic [DATA_W-1:0] pix_r;

  logic              disp_slot;
  logic              issue_sel;
  logic              req_oob;
  logic [CALC_W-1:0] disp_x_term;
  logic [CALC_W-1:0] disp_y_row;
  logic [CALC_W-1:0] disp_addr;
  logic [CALC_W-1:0] query_addr;

  // Visible-pixel detection: the display owns the ROM in these cycles
  always_comb begin
    disp_slot = (bus.DrawX < H_VIS_C) && (bus.DrawY < V_VIS_C);
  end

  // Screen-to-image scaling for the display fetch, truncating each term
  always_comb begin
    disp_x_term = (CALC_W'(bus.DrawX) * IMG_W_K) / H_VIS_K;
    disp_y_row  = (CALC_W'(bus.DrawY) * IMG_H_K) / V_VIS_K;
    disp_addr   = disp_x_term + disp_y_row * IMG_W_K;
    query_addr  = CALC_W'(q_y_l) * IMG_W_K + CALC_W'(q_x_l);
  end

  // ROM address mux; the query only gets the ROM in ISSUE outside a visible slot
  always_comb begin
    issue_sel = (state == S_ISSUE) && !disp_slot;
    if (!reset_n) begin
      bus.rom_address = '0;
    end else if (issue_sel) begin
      bus.rom_address = ADDR_W'(query_addr);
    end else begin
      bus.rom_address = ADDR_W'(disp_addr);
    end
  end

  // Display pipeline: visibility travels alongside the ROM read, then the index is registered
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d1 <= 1'b0;
      pix_r    <= '0;
    end else begin
      blank_d1 <= bus.blank;
      pix_r    <= blank_d1 ? bus.rom_q : '0;
    end
  end

  // Query FSM state and registered handshake outputs
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      q_x_l    <= '0;
      q_y_l    <= '0;
      q_ack_r  <= 1'b0;
      q_data_r <= '0;
      q_oob_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      q_x_l    <= q_x_nxt;
      q_y_l    <= q_y_nxt;
      q_ack_r  <= q_ack_nxt;
      q_data_r <= q_data_nxt;
      q_oob_r  <= q_oob_nxt;
    end
  end

  // Query FSM next state; q_ack is raised on every transition into DONE
  always_comb begin
    state_nxt  = state;
    q_x_nxt    = q_x_l;
    q_y_nxt    = q_y_l;
    q_ack_nxt  = 1'b0;
    q_data_nxt = q_data_r;
    q_oob_nxt  = q_oob_r;
    req_oob    = (bus.q_x >= IMG_W_C) || (bus.q_y >= IMG_H_C);
    case (state)
      S_IDLE: begin
        if (bus.q_req) begin
          q_x_nxt = bus.q_x;
          q_y_nxt = bus.q_y;
          if (req_oob) begin
            state_nxt  = S_DONE;
            q_ack_nxt  = 1'b1;
            q_data_nxt = '0;
            q_oob_nxt  = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!disp_slot) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The address was driven in the previous (ISSUE) cycle, so rom_q is ours
        state_nxt  = S_DONE;
        q_ack_nxt  = 1'b1;
        q_data_nxt = bus.rom_q;
        q_oob_nxt  = 1'b0;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef BGARB_PERF_EN
  logic [15:0] wait_cnt;
  logic        stall;

  // Saturating count of cycles a query spends blocked by the display
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (stall && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Stall qualifier for the counter
  always_comb begin
    stall = (state == S_ISSUE) && disp_slot;
  end

  assign bus.q_wait_cycles = wait_cnt;
`else
  assign bus.q_wait_cycles = 16'd0;
`endif

  assign bus.pix_index = pix_r;
  assign bus.q_ack     = q_ack_r;
  assign bus.q_data    = q_data_r;
  assign bus.q_oob     = q_oob_r;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed bench for bg_rom_arbiter: table-driven display fetch vectors plus
// hand-written query sequences (hblank, out-of-bounds, stalled, reset mid-query).
module tb_bg_rom_arbiter;

  logic clk;
  logic rst_n;

  bg_rom_arbiter_if #(.ADDR_W(15), .DATA_W(4)) bus ();

  bg_rom_arbiter dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background ROM contents used by the bench
  function automatic logic [3:0] rom_fn(input logic [14:0] a);
    if (a == 15'd0)   return 4'd5;
    if (a == 15'd213) return 4'd9;
    return a[3:0] ^ a[7:4];
  endfunction

  // Synchronous ROM model, 1-cycle read latency
  always_ff @(posedge clk) bus.rom_q <= rom_fn(bus.rom_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [14:0] addr;
    logic [3:0]  pix;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  int ack_at;
  int acked_x;
  logic [15:0] exp_wait;

  initial begin
    vt[0] = '{10'd0,   10'd0,   1'b1, 15'd0,     4'd5};
    vt[1] = '{10'd639, 10'd479, 1'b1, 15'd12284, 4'd3};
    vt[2] = '{10'd639, 10'd479, 1'b0, 15'd12284, 4'd0};
    vt[3] = '{10'd320, 10'd240, 1'b1, 15'd6142,  4'd1};
    vt[4] = '{10'd100, 10'd300, 1'b1, 15'd7681,  4'd1};
    vt[5] = '{10'd1,   10'd1,   1'b0, 15'd0,     4'd0};
    vt[6] = '{10'd639, 10'd0,   1'b1, 15'd104,   4'd14};
    vt[7] = '{10'd0,   10'd479, 1'b1, 15'd12180, 4'd13};

`ifdef BGARB_PERF_EN
    exp_wait = 16'd10;
`else
    exp_wait = 16'd0;
`endif

    // Reset state
    rst_n = 1'b0;
    bus.DrawX = 10'd5; bus.DrawY = 10'd5; bus.blank = 1'b1;
    bus.q_req = 1'b0;  bus.q_x = 10'd0;   bus.q_y = 10'd0;
    tick(); tick();
    chk("rst_addr",  32'(bus.rom_address),   32'd0);
    chk("rst_pix",   32'(bus.pix_index),     32'd0);
    chk("rst_ack",   32'(bus.q_ack),         32'd0);
    chk("rst_data",  32'(bus.q_data),        32'd0);
    chk("rst_oob",   32'(bus.q_oob),         32'd0);
    chk("rst_wait",  32'(bus.q_wait_cycles), 32'd0);
    rst_n = 1'b1;
    tick();

    // Display fetch vectors, pipelined one per cycle
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) begin
        bus.DrawX = vt[i].x; bus.DrawY = vt[i].y; bus.blank = vt[i].blank;
      end else begin
        bus.DrawX = 10'd700; bus.DrawY = 10'd10; bus.blank = 1'b0;
      end
      #1;
      if (i < NV) chk($sformatf("disp_addr[%0d]", i), 32'(bus.rom_address), 32'(vt[i].addr));
      if (i >= 2) chk($sformatf("disp_pix[%0d]", i - 2), 32'(bus.pix_index), 32'(vt[i-2].pix));
      chk($sformatf("disp_noack[%0d]", i), 32'(bus.q_ack), 32'd0);
      tick();
    end

    // In-bounds query during hblank: ack at c3
    bus.DrawX = 10'd700; bus.DrawY = 10'd10; bus.blank = 1'b0;
    bus.q_req = 1'b1; bus.q_x = 10'd3; bus.q_y = 10'd2;
    #1; chk("hb_c0_ack", 32'(bus.q_ack), 32'd0);
    tick(); chk("hb_c1_addr", 32'(bus.rom_address), 32'd213);
    chk("hb_c1_ack", 32'(bus.q_ack), 32'd0);
    tick(); chk("hb_c2_ack", 32'(bus.q_ack), 32'd0);
    tick(); chk("hb_c3_ack", 32'(bus.q_ack), 32'd1);
    chk("hb_c3_data", 32'(bus.q_data), 32'd9);
    chk("hb_c3_oob",  32'(bus.q_oob),  32'd0);
    bus.q_req = 1'b0;
    tick(); chk("hb_c4_ack", 32'(bus.q_ack), 32'd0);
    chk("hb_c4_hold", 32'(bus.q_data), 32'd9);

    // Out-of-bounds query: ack at c1, no query address
    bus.q_req = 1'b1; bus.q_x = 10'd105; bus.q_y = 10'd0;
    #1; chk("oob_c0_addr", 32'(bus.rom_address), 32'd324);
    tick(); chk("oob_c1_ack", 32'(bus.q_ack), 32'd1);
    chk("oob_c1_oob",  32'(bus.q_oob),  32'd1);
    chk("oob_c1_data", 32'(bus.q_data), 32'd0);
    chk("oob_c1_addr", 32'(bus.rom_address), 32'd324);
    bus.q_req = 1'b0;
    tick(); chk("oob_c2_ack", 32'(bus.q_ack), 32'd0);
    chk("oob_c2_hold", 32'(bus.q_oob), 32'd1);

    // Query stalled by visible pixels until DrawX reaches 640
    bus.DrawY = 10'd100; bus.DrawX = 10'd629; bus.blank = 1'b1;
    bus.q_req = 1'b1; bus.q_x = 10'd0; bus.q_y = 10'd0;
    acked_x = -1;
    for (int k = 0; k < 40 && acked_x < 0; k++) begin
      #1;
      if (bus.DrawX == 10'd635) chk("stall_disp_wins", 32'(bus.rom_address), 32'd2624);
      if (bus.DrawX == 10'd640) chk("stall_issue_addr", 32'(bus.rom_address), 32'd0);
      if (bus.q_ack) begin
        acked_x = int'(bus.DrawX);
        chk("stall_data", 32'(bus.q_data), 32'd5);
        chk("stall_oob",  32'(bus.q_oob),  32'd0);
      end
      tick();
      bus.DrawX = bus.DrawX + 10'd1;
      if (acked_x >= 0) bus.q_req = 1'b0;
    end
    chk("stall_ack_x", 32'(acked_x), 32'd642);
    chk("stall_wait_cycles", 32'(bus.q_wait_cycles), 32'(exp_wait));

    // Reset asserted while the query is in WAIT; q_req stays high across reset
    bus.DrawX = 10'd700; bus.DrawY = 10'd10; bus.blank = 1'b1;
    bus.q_req = 1'b1; bus.q_x = 10'd3; bus.q_y = 10'd2;
    tick();
    chk("rw_c1_addr", 32'(bus.rom_address), 32'd213);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_ack",  32'(bus.q_ack),         32'd0);
    chk("rw_data", 32'(bus.q_data),        32'd0);
    chk("rw_oob",  32'(bus.q_oob),         32'd0);
    chk("rw_pix",  32'(bus.pix_index),     32'd0);
    chk("rw_addr", 32'(bus.rom_address),   32'd0);
    chk("rw_wait", 32'(bus.q_wait_cycles), 32'd0);
    tick();
    chk("rw_ack_held", 32'(bus.q_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    ack_at = -1;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (bus.q_ack && ack_at < 0) begin
        ack_at = j;
        chk("rw_new_data", 32'(bus.q_data), 32'd9);
      end
      tick();
      if (ack_at >= 0) bus.q_req = 1'b0;
    end
    chk("rw_new_ack_at", 32'(ack_at), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
